hello_streamer: RTL and testbench
=================================

# hello_streamer

Parametrised message streamer, the successor to our console-print demo: a small writable character RAM holds a message, and on command the block emits it one character per valid/ready transfer. The pass can be repeated N times with a fixed idle gap between passes, or run until aborted. It sits between a host/config port and any byte-wide sink (UART TX, display driver, testbench monitor). All logic is on one clock with no combinational path from i_ready to o_valid.

## Interface
- DATA_W, 8, character width in bits
- MSG_LEN, 16, message RAM depth (max characters per pass), ≥2
- LEN_W, $clog2(MSG_LEN+1), width of length fields
- CNT_W, 8, repeat-count width
- GAP_CYCLES, 4, idle cycles between passes, ≥0

- i_clock  in  1  rising-edge clock
- i_reset  in  1  synchronous, active-high reset
- i_wr_en  in  1  message RAM write strobe
- i_wr_addr  in  $clog2(MSG_LEN)  RAM write address
- i_wr_data  in  DATA_W  RAM write data
- i_len  in  LEN_W  characters per pass, sampled with i_start
- i_repeat  in  CNT_W  number of passes; 0 = continuous
- i_start  in  1  start pulse, honoured in IDLE only
- i_abort  in  1  stop immediately, return to IDLE
- o_data  out  DATA_W  current character
- o_valid  out  1  o_data valid
- i_ready  in  1  sink accepts o_data this cycle
- o_busy  out  1  high in SEND and GAP
- o_done  out  1  one-cycle pulse after final pass completes
- o_pass_cnt  out  CNT_W  passes completed in current run

## Operation
- States: IDLE, SEND, GAP, DONE.
- Reset: state IDLE; o_valid=0, o_busy=0, o_done=0, o_data=0, o_pass_cnt=0, internal index and counters 0. RAM contents unaffected by reset.
- RAM write: when i_wr_en and state is IDLE, mem[i_wr_addr] <= i_wr_data. Writes outside IDLE are ignored. Addresses ≥ MSG_LEN are ignored.
- IDLE + i_start: latch len = min(i_len, MSG_LEN) and rep = i_repeat. Clear o_pass_cnt and idx.
  - If len == 0, go to DONE.
  - Otherwise go to SEND.
- SEND: o_valid=1, o_data=mem[idx].
  - On a transfer (o_valid & i_ready) with idx < len-1: idx+1.
  - On a transfer with idx == len-1: idx=0 and o_pass_cnt+1 (wraps modulo 2^CNT_W). Then:
    - If rep != 0 and the new count == rep, go to DONE.
    - Else if GAP_CYCLES > 0, go to GAP.
    - Else stay in SEND with idx=0, giving back-to-back passes.
- GAP: o_valid=0; count GAP_CYCLES cycles, then SEND.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_pass_cnt holds its final value until the next i_start.
- i_abort in any state has priority over all other events: next state IDLE, o_valid=0, no o_done pulse, o_pass_cnt holds.
- i_start outside IDLE is ignored. i_start and i_abort together in IDLE: abort wins, stays IDLE.

## Timing
- All outputs are registered.
- i_start at edge N → o_valid=1 with mem[0] from edge N+1.
- Throughput: one character per cycle while i_ready=1; no bubble between characters within a pass.
- While o_valid & !i_ready, o_data and o_valid hold stable (AXI-style). Once asserted, o_valid never drops without a transfer, except on i_abort or i_reset.
- Inter-pass bubble: exactly GAP_CYCLES cycles with o_valid=0.
- Final transfer at edge M → o_done=1 in cycle M+1, IDLE at M+2. A new i_start is accepted in IDLE from M+2.
- len==0: i_start at N → o_done in cycle N+1, with zero transfers.
- i_reset mid-run: outputs take their reset values at the next edge; the in-flight character is dropped.

## Test plan
- Load "Hello" (0x48,0x65,0x6C,0x6C,0x6F); i_len=5, i_repeat=1, i_ready=1 → 5 consecutive beats, o_done one cycle after the 0x6F beat, o_pass_cnt=1.
- Same message, i_repeat=3, GAP_CYCLES=4 → 15 beats, exactly 4 idle cycles between passes, o_pass_cnt=3, a single o_done.
- Randomised i_ready (50%) → o_data stable during stalls, no duplicated or lost characters, exact "Hello" sequence.
- i_repeat=0 and i_abort after 12 beats → o_valid low next cycle, no o_done, state IDLE; o_pass_cnt=2 (passes completed before the abort).
- i_len=0 → o_done one cycle after i_start, no o_valid. i_len=20 with MSG_LEN=16 → 16 beats per pass.
- i_wr_en while busy → RAM unchanged (verify on the next run); i_reset mid-pass → all outputs 0 next cycle.

Source files
------------

// File: rtl/hello_streamer.sv
// hello_streamer: streams a message held in a small writable character RAM
// over a valid/ready byte interface. A run can repeat the message a set
// number of times, or until aborted, with a fixed idle gap between passes.
module hello_streamer #(
  parameter int DATA_W     = 8,
  parameter int MSG_LEN    = 16,
  parameter int LEN_W      = $clog2(MSG_LEN + 1),
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [LEN_W-1:0]           i_len,
  input  logic [CNT_W-1:0]           i_repeat,
  input  logic                       i_start,
  input  logic                       i_abort,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [CNT_W-1:0]           o_pass_cnt
);

  localparam int AW = $clog2(MSG_LEN);
  // Gap counter is kept at least one bit wide even when no gap is used.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem [MSG_LEN];

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic              xfer;
  logic              last_char;
  logic              addr_ok;
  logic [LEN_W-1:0]  len_clamped;

  // Out-of-range write addresses can only exist when the RAM depth is not a
  // power of two; otherwise every address is valid.
  generate
    if (MSG_LEN == (2 ** AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (i_wr_addr < AW'(MSG_LEN));
    end
  endgenerate

  assign xfer        = valid_q & i_ready;
  assign last_char   = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
  assign len_clamped = (i_len > LEN_W'(MSG_LEN)) ? LEN_W'(MSG_LEN) : i_len;

  // Message RAM write port; the RAM is frozen while a run is in progress.
  always_ff @(posedge i_clock) begin
    if (i_wr_en && (state_q == S_IDLE) && addr_ok) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Next-state and counter logic; abort overrides every other event.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    rep_d      = rep_q;
    pass_cnt_d = pass_cnt_q;
    gap_d      = gap_q;
    if (i_abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            len_d      = len_clamped;
            rep_d      = i_repeat;
            pass_cnt_d = '0;
            idx_d      = '0;
            gap_d      = '0;
            state_d    = (len_clamped == '0) ? S_DONE : S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (last_char) begin
              idx_d      = '0;
              pass_cnt_d = pass_cnt_q + CNT_W'(1);
              if ((rep_q != '0) && (pass_cnt_d == rep_q)) begin
                state_d = S_DONE;
              end else if (GAP_CYCLES > 0) begin
                state_d = S_GAP;
                gap_d   = '0;
              end
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            state_d = S_SEND;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; the character is read from RAM at the
  // address the next cycle will present, so o_data is ready with o_valid.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      pass_cnt_q <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      pass_cnt_q <= pass_cnt_d;
      gap_q      <= gap_d;
      valid_q    <= (state_d == S_SEND);
      busy_q     <= (state_d == S_SEND) || (state_d == S_GAP);
      done_q     <= (state_d == S_DONE);
      if (state_d == S_SEND) begin
        data_q <= mem[idx_d];
      end
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_hello_streamer.sv
// Bench for hello_streamer: directed runs with a scoreboard queue of expected
// characters, popped by an independent monitor on every accepted beat.
`timescale 1ns/1ps
module tb_hello_streamer;
  localparam int DATA_W     = 8;
  localparam int MSG_LEN    = 16;
  localparam int LEN_W      = $clog2(MSG_LEN + 1);
  localparam int CNT_W      = 8;
  localparam int GAP_CYCLES = 4;
  localparam int AW         = $clog2(MSG_LEN);

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_wr_en = 1'b0;
  logic [AW-1:0]     i_wr_addr = '0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic [LEN_W-1:0]  i_len = '0;
  logic [CNT_W-1:0]  i_repeat = '0;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic              o_busy;
  logic              o_done;
  logic [CNT_W-1:0]  o_pass_cnt;

  hello_streamer #(
    .DATA_W(DATA_W), .MSG_LEN(MSG_LEN), .LEN_W(LEN_W),
    .CNT_W(CNT_W), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_wr_en(i_wr_en),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_len(i_len),
    .i_repeat(i_repeat), .i_start(i_start), .i_abort(i_abort),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy), .o_done(o_done), .o_pass_cnt(o_pass_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] img [MSG_LEN];
  logic [DATA_W-1:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

  // Results of the most recent observe() call.
  int beats, dones, done_at, last_beat;
  int gaps [$];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the head of the queue,
  // and a stalled beat must hold its value into the next cycle.
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid_hold", o_valid, 1);
      check("stall_data_hold", o_data, prev_data);
    end
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data 0x%02h, expected no beat", o_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        $display("[TB] beat data=0x%02h expected=0x%02h", o_data, e);
        check("beat_data", o_data, e);
      end
    end
    prev_stall = (o_valid === 1'b1) && !i_ready && !i_abort && !i_reset;
    prev_data  = o_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ram(input int addr, input logic [DATA_W-1:0] data);
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(addr);
    i_wr_data = data;
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic start(input int len, input int rep);
    i_len    = LEN_W'(len);
    i_repeat = CNT_W'(rep);
    i_start  = 1'b1;
    tick();
    i_start  = 1'b0;
  endtask

  task automatic push_msg(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(img[i]);
  endtask

  // Sample one run cycle by cycle until the cycle after o_done (bounded).
  task automatic observe(input int budget, input bit rand_ready);
    int gap_run;
    beats = 0; dones = 0; done_at = -1; last_beat = -1; gap_run = 0;
    gaps.delete();
    for (int c = 0; c < budget; c++) begin
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
      if (o_valid && i_ready) begin
        beats++;
        last_beat = c;
      end
      if (o_busy && !o_valid) gap_run++;
      else if (gap_run > 0) begin
        gaps.push_back(gap_run);
        gap_run = 0;
      end
      if (o_done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c == done_at + 1) break;
      tick();
    end
    i_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  found;
    int  seen_done, seen_valid;

    // Reset values
    repeat (3) tick();
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_data", o_data, 0);
    check("rst_pass_cnt", o_pass_cnt, 0);
    i_reset = 1'b0;
    tick();

    // Load "Hello" followed by a filler pattern
    for (int i = 0; i < MSG_LEN; i++) begin
      img[i] = (i < 5) ? hello[i] : DATA_W'(8'h41 + i);
      write_ram(i, img[i]);
    end

    // 1: single pass
    i_ready = 1'b1;
    push_msg(5);
    start(5, 1);
    observe(100, 1'b0);
    check("t1_beats", beats, 5);
    check("t1_dones", dones, 1);
    check("t1_done_at", done_at, 5);
    check("t1_last_beat", last_beat, 4);
    check("t1_pass_cnt", o_pass_cnt, 1);
    check("t1_gaps", gaps.size(), 0);
    check("t1_busy_after", o_busy, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: three passes with gaps
    push_msg(5); push_msg(5); push_msg(5);
    start(5, 3);
    observe(200, 1'b0);
    check("t2_beats", beats, 15);
    check("t2_dones", dones, 1);
    check("t2_done_at", done_at, 23);
    check("t2_gap_count", gaps.size(), 2);
    foreach (gaps[i]) check("t2_gap_len", gaps[i], GAP_CYCLES);
    check("t2_pass_cnt", o_pass_cnt, 3);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: random backpressure
    push_msg(5);
    start(5, 1);
    observe(300, 1'b1);
    check("t3_beats", beats, 5);
    check("t3_dones", dones, 1);
    check("t3_pass_cnt", o_pass_cnt, 1);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: continuous run aborted after 12 beats
    push_msg(5); push_msg(5); push_msg(2);
    start(5, 0);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (n == 12) break;
      if (o_valid && i_ready) n++;
      tick();
    end
    check("t4_beats_before_abort", n, 12);
    i_abort = 1'b1;
    i_ready = 1'b0;
    tick();
    i_abort = 1'b0;
    i_ready = 1'b1;
    check("t4_valid", o_valid, 0);
    check("t4_busy", o_busy, 0);
    check("t4_done", o_done, 0);
    check("t4_pass_cnt", o_pass_cnt, 2);
    seen_done = 0; seen_valid = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen_done  += int'(o_done);
      seen_valid += int'(o_valid);
    end
    check("t4_no_done_later", seen_done, 0);
    check("t4_no_valid_later", seen_valid, 0);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: zero length
    start(0, 1);
    check("t5_done", o_done, 1);
    check("t5_valid", o_valid, 0);
    check("t5_busy", o_busy, 0);
    tick();
    check("t5_done_pulse", o_done, 0);
    check("t5_pass_cnt", o_pass_cnt, 0);

    // 5b: start and abort together stay idle
    i_len = 5; i_repeat = 1; i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    check("t5b_busy", o_busy, 0);
    check("t5b_valid", o_valid, 0);
    tick();
    check("t5b_done", o_done, 0);

    // 6: length clamped to RAM depth
    push_msg(MSG_LEN);
    start(20, 1);
    observe(200, 1'b0);
    check("t6_beats", beats, MSG_LEN);
    check("t6_done_at", done_at, MSG_LEN);
    check("t6_pass_cnt", o_pass_cnt, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    // 7: writes while busy are ignored
    i_ready = 1'b0;
    start(5, 1);
    i_wr_en = 1'b1; i_wr_addr = '0; i_wr_data = 8'h5A;
    tick();
    tick();
    i_wr_en = 1'b0;
    check("t7_stalled_valid", o_valid, 1);
    check("t7_stalled_data", o_data, 8'h48);
    push_msg(5);
    i_ready = 1'b1;
    observe(100, 1'b0);
    check("t7_beats", beats, 5);
    push_msg(5);
    start(5, 1);
    observe(100, 1'b0);
    check("t7_rerun_beats", beats, 5);
    check("t7_queue_empty", exp_q.size(), 0);

    // 8: reset in the middle of the second pass
    push_msg(5); push_msg(5);
    start(5, 3);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (o_pass_cnt == 1 && o_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t8_reached_pass2", found, 1);
    i_ready = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    exp_q.delete();
    check("t8_valid", o_valid, 0);
    check("t8_busy", o_busy, 0);
    check("t8_done", o_done, 0);
    check("t8_data", o_data, 0);
    check("t8_pass_cnt", o_pass_cnt, 0);
    i_ready = 1'b1;
    tick();
    check("t8_stays_idle", o_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
